// File: rtl/sumador_rr_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared SUMADORQ22 adder.
// Define SUMADOR_ARB_FIXPRI_EN for fixed priority (requester 0 wins ties).
module sumador_rr_arbiter #(
  parameter int W   = 5,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W:0]   rsp_sum,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(LAT + 1);

  state_t     state_q;
  state_t     state_d;
  logic       last_q;
  logic [2:0] cnt_q;
  logic       win;
  logic       idle;
  logic       hs;

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0_valid && !req1_valid): win = 1'b0;
      (req1_valid && !req0_valid): win = 1'b1;
      (req0_valid && req1_valid): begin
`ifdef SUMADOR_ARB_FIXPRI_EN
        win = 1'b0;
`else
        win = ~last_q;
`endif
      end
      default: win = 1'b0;
    endcase
  end

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle && req0_valid && !win;
  assign req1_ready = idle && req1_valid && win;
  assign hs         = (req0_valid && req0_ready) ||
                      (req1_valid && req1_ready);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = !idle;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands stay on the adder until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 3'd0;
      add_a   <= '0;
      add_b   <= '0;
      rsp_id  <= 1'b0;
      rsp_sum <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            add_a  <= win ? req1_a : req0_a;
            add_b  <= win ? req1_b : req0_b;
            rsp_id <= win;
            cnt_q  <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) rsp_sum <= add_c;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        RESP: begin
          if (rsp_ready) last_q <= rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_rr_arbiter.sv
// Directed self-checking bench for sumador_rr_arbiter.
// Adder is modelled in the bench with a LAT-cycle registered pipeline.
module tb_sumador_rr_arbiter;

  localparam int W   = 5;
  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W:0]   add_c;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [W:0]   rsp_sum;
  logic         busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sumador_rr_arbiter #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  logic [W:0] comb_sum;
  logic [W:0] sh [0:6];
  assign comb_sum = {1'b0, add_a} + {1'b0, add_b};
  always @(posedge clk) begin
    sh[0] <= comb_sum;
    for (int i = 1; i < 7; i++) sh[i] <= sh[i-1];
  end
  assign add_c = (LAT == 0) ? comb_sum : sh[(LAT == 0) ? 0 : LAT-1];

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one transaction with rsp_ready high; returns what was observed.
  task automatic txn(
    input  logic         v0, input logic v1,
    input  logic [W-1:0] a0, input logic [W-1:0] b0,
    input  logic [W-1:0] a1, input logic [W-1:0] b1,
    output logic r0, output logic r1, output logic early,
    output logic got, output logic [W:0] sum, output logic id);
    rsp_ready = 1'b1;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    r0 = req0_ready;
    r1 = req1_ready;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    early = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk);
      if (rsp_valid) early = 1'b1;
    end
    @(negedge clk);
    got = rsp_valid;
    sum = rsp_sum;
    id  = rsp_id;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (add_a !== 5'd0) begin failures++;
      $display("FAIL rst_add_a got=%0d exp=0", add_a); end
    checks++; if (add_b !== 5'd0) begin failures++;
      $display("FAIL rst_add_b got=%0d exp=0", add_b); end
    checks++; if (rsp_valid !== 1'b0) begin failures++;
      $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin failures++;
      $display("FAIL rst_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (rsp_sum !== 6'd0) begin failures++;
      $display("FAIL rst_rsp_sum got=%0d exp=0", rsp_sum); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++;
      $display("FAIL rst_rel_ready got=%b exp=1", req0_ready); end
    req0_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic r0, r1, early, got, id;
    logic [W:0] sum;
    txn(1, 0, 5'd31, 5'd31, 5'd0, 5'd0, r0, r1, early, got, sum, id);
    checks++; if ({r0, r1} !== 2'b10) begin failures++;
      $display("FAIL basic_ready got=%b exp=10", {r0, r1}); end
    checks++; if (early !== 1'b0) begin failures++;
      $display("FAIL basic_early got=%b exp=0", early); end
    checks++; if (got !== 1'b1) begin failures++;
      $display("FAIL basic_valid got=%b exp=1", got); end
    checks++; if (sum !== 6'd62) begin failures++;
      $display("FAIL basic_sum got=%0d exp=62", sum); end
    checks++; if (id !== 1'b0) begin failures++;
      $display("FAIL basic_id got=%b exp=0", id); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL basic_idle got=%b exp=0", busy); end
  endtask

  task automatic test_alternate();
    logic r0, r1, early, got, id;
    logic [W:0] sum;
    do_reset();
    txn(1, 1, 5'd3, 5'd4, 5'd10, 5'd20, r0, r1, early, got, sum, id);
    checks++; if ({id, sum} !== {1'b0, 6'd7}) begin failures++;
      $display("FAIL alt1 got=%b/%0d exp=0/7", id, sum); end
    txn(1, 1, 5'd3, 5'd4, 5'd10, 5'd20, r0, r1, early, got, sum, id);
`ifdef SUMADOR_ARB_FIXPRI_EN
    checks++; if ({id, sum} !== {1'b0, 6'd7}) begin failures++;
      $display("FAIL alt2 got=%b/%0d exp=0/7", id, sum); end
`else
    checks++; if ({id, sum} !== {1'b1, 6'd30}) begin failures++;
      $display("FAIL alt2 got=%b/%0d exp=1/30", id, sum); end
`endif
    txn(1, 1, 5'd1, 5'd2, 5'd5, 5'd6, r0, r1, early, got, sum, id);
    checks++; if ({id, sum} !== {1'b0, 6'd3}) begin failures++;
      $display("FAIL alt3 got=%b/%0d exp=0/3", id, sum); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 5'd16; req0_b = 5'd16;
    @(posedge clk);
    @(negedge clk);
    req0_a = 5'd1; req0_b = 5'd1;
    req1_valid = 1'b1; req1_a = 5'd2; req1_b = 5'd2;
    repeat (LAT + 1) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, busy} !== {1'b1, 1'b0, 6'd32, 1'b1})
      begin failures++;
        $display("FAIL bp_hold[%0d] got v=%b id=%b s=%0d b=%b exp 1/0/32/1",
                 k, rsp_valid, rsp_id, rsp_sum, busy); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++;
        $display("FAIL bp_ready[%0d] got=%b exp=00", k,
                 {req0_ready, req1_ready}); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({busy, rsp_valid} !== 2'b00) begin failures++;
      $display("FAIL bp_release got=%b exp=00", {busy, rsp_valid}); end
`ifdef SUMADOR_ARB_FIXPRI_EN
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++;
      $display("FAIL bp_regrant got=%b exp=10", {req0_ready, req1_ready}); end
`else
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++;
      $display("FAIL bp_regrant got=%b exp=01", {req0_ready, req1_ready}); end
`endif
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    req0_valid = 1'b1; req0_a = 5'd9; req0_b = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL mid_busy got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy} !== 19'd0) begin
      failures++;
      $display("FAIL mid_clear got a=%0d b=%0d v=%b id=%b s=%0d busy=%b exp all 0",
               add_a, add_b, rsp_valid, rsp_id, rsp_sum, busy); end
    req0_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++;
      $display("FAIL mid_ready got=%b exp=1", req0_ready); end
    req0_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL mid_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic r0, r1, early, got, id;
    logic [W:0] sum;
    logic [3:0] ids;
`ifdef SUMADOR_ARB_FIXPRI_EN
    logic [3:0] exp_ids = 4'b0000;
`else
    logic [3:0] exp_ids = 4'b1010;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      txn(1, 1, 5'(k), 5'd1, 5'(k + 8), 5'd1, r0, r1, early, got, sum, id);
      ids[k] = id;
      checks++;
      if (sum !== (id ? 6'(k + 9) : 6'(k + 1))) begin failures++;
        $display("FAIL b2b_sum[%0d] got=%0d exp=%0d", k, sum,
                 id ? k + 9 : k + 1); end
    end
    checks++; if (ids !== exp_ids) begin failures++;
      $display("FAIL b2b_ids got=%b exp=%b", ids, exp_ids); end
  endtask

  task automatic test_zero_req1();
    logic r0, r1, early, got, id;
    logic [W:0] sum;
    txn(0, 1, 5'd0, 5'd0, 5'd0, 5'd0, r0, r1, early, got, sum, id);
    checks++; if ({r0, r1} !== 2'b01) begin failures++;
      $display("FAIL zero_ready got=%b exp=01", {r0, r1}); end
    checks++; if ({early, got} !== 2'b01) begin failures++;
      $display("FAIL zero_timing got=%b exp=01", {early, got}); end
    checks++; if ({id, sum} !== {1'b1, 6'd0}) begin failures++;
      $display("FAIL zero_rsp got=%b/%0d exp=1/0", id, sum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_zero_req1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
